// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// Contents: state enum, clog2 and counter-width functions, status widths.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        OFF,
        RESET,
        WAIT_LOCK,
        SETTLE,
        RUN,
        FAULT
    } state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return r;
    endfunction

    // One counter covers every timed state, so size it for the longest.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the sequencer and the PLL / reset tree.
// master: sequencer side (drives PLL pins and status); slave: environment.
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic               enable;
    logic               pll_locked;
    logic               pll_rst;
    logic               pll_pwrdwn;
    logic               sys_reset;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_count;
    logic [LOSS_W-1:0]  lock_loss_count;

    modport master (
        input  enable, pll_locked,
        output pll_rst, pll_pwrdwn, sys_reset,
        output ready, fault, retry_count, lock_loss_count
    );

    modport slave (
        output enable, pll_locked,
        input  pll_rst, pll_pwrdwn, sys_reset,
        input  ready, fault, retry_count, lock_loss_count
    );
endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for asynchronous status pins (e.g. PLL LOCKED).
// Ports: clk, reset (async, high), d (async in), q (synchronized out).
module pll_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences a PLL through power-down, reset, lock and settle; holds sys_reset.
// Ports: clk, reset (async, high); bus (master): enable/pll_locked in, rest out.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int SETTLE_CYCLES       = 256,
    parameter int MAX_RETRIES         = 3
) (
    input logic                   clk,
    input logic                   reset,
    pll_reset_sequencer_if.master bus
);
    localparam int CW = cnt_width(RST_HOLD_CYCLES,
                                  LOCK_TIMEOUT_CYCLES,
                                  SETTLE_CYCLES);

    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [RETRY_W-1:0] retry, retry_nx;
    logic [LOSS_W-1:0]  loss, loss_nx;
    logic               locked_s;
    logic               fail;
    logic               rst_q, pwr_q, sys_q, rdy_q, flt_q;
    logic               rst_nx, pwr_nx, sys_nx, rdy_nx, flt_nx;

    pll_lock_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_nx = state;
        retry_nx = retry;
        loss_nx  = loss;
        fail     = 1'b0;
        unique case (state)
            OFF: begin
                if (bus.enable) begin
                    state_nx = RESET;
                    retry_nx = '0;
                end
            end
            RESET: begin
                if (cnt == CW'(RST_HOLD_CYCLES - 1))
                    state_nx = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s)
                    state_nx = SETTLE;
                else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1))
                    fail = 1'b1;
            end
            SETTLE: begin
                if (!locked_s)
                    fail = 1'b1;
                else if (cnt == CW'(SETTLE_CYCLES - 1))
                    state_nx = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    state_nx = RESET;
                    retry_nx = '0;
                    if (loss != '1)
                        loss_nx = loss + 1'b1;
                end
            end
            FAULT: begin
                state_nx = FAULT;
            end
            default: begin
                state_nx = OFF;
            end
        endcase

        if (fail) begin
            retry_nx = retry + 1'b1;
            state_nx = (retry_nx == RETRY_W'(MAX_RETRIES)) ? FAULT : RESET;
        end

        // Power-down request beats every other transition, including counts.
        if (!bus.enable) begin
            state_nx = OFF;
            retry_nx = retry;
            loss_nx  = loss;
        end

        if (state_nx != state ||
            !(state inside {RESET, WAIT_LOCK, SETTLE}))
            cnt_nx = '0;
        else
            cnt_nx = cnt + 1'b1;
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        rst_nx = 1'b0;
        pwr_nx = 1'b0;
        sys_nx = 1'b1;
        rdy_nx = 1'b0;
        flt_nx = 1'b0;
        unique case (state_nx)
            OFF: begin
                rst_nx = 1'b1;
                pwr_nx = 1'b1;
            end
            RESET: begin
                rst_nx = 1'b1;
            end
            WAIT_LOCK, SETTLE: begin
                rst_nx = 1'b0;
            end
            RUN: begin
                sys_nx = 1'b0;
                rdy_nx = 1'b1;
            end
            FAULT: begin
                rst_nx = 1'b1;
                flt_nx = 1'b1;
            end
            default: begin
                rst_nx = 1'b1;
                pwr_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= OFF;
            cnt   <= '0;
            retry <= '0;
            loss  <= '0;
            rst_q <= 1'b1;
            pwr_q <= 1'b1;
            sys_q <= 1'b1;
            rdy_q <= 1'b0;
            flt_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            retry <= retry_nx;
            loss  <= loss_nx;
            rst_q <= rst_nx;
            pwr_q <= pwr_nx;
            sys_q <= sys_nx;
            rdy_q <= rdy_nx;
            flt_q <= flt_nx;
        end
    end

    assign bus.pll_rst         = rst_q;
    assign bus.pll_pwrdwn      = pwr_q;
    assign bus.sys_reset       = sys_q;
    assign bus.ready           = rdy_q;
    assign bus.fault           = flt_q;
    assign bus.retry_count     = retry;
    assign bus.lock_loss_count = loss;
endmodule
